// File: rtl/lcd_bus_driver_pkg.sv
// Shared constants, state encoding and helpers for the LCD parallel bus driver.
package lcd_pkg;

    localparam logic [8:0] LCD_CMD_NOP      = 9'h100;
    localparam int         LCD_CMD_FLAG_BIT = 8;

    typedef enum logic [2:0] {
        PWRUP,
        IDLE,
        FETCH,
        SETUP,
        WR_LO,
        WR_HI
    } bus_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lcd_bus_driver_if.sv
// Command-stream handshake from lcd_controller plus the 8080-style LCD write bus.
interface lcd_bus_driver_if;

    logic [8:0] cmd_data;
    logic       cmd_pull;
    logic       cmd_ready;
    logic       lcd_csx;
    logic       lcd_dcx;
    logic       lcd_wrx;
    logic       lcd_rdx;
    logic [7:0] lcd_d;

    modport master (
        input  cmd_data,
        output cmd_pull,
        output cmd_ready,
        output lcd_csx,
        output lcd_dcx,
        output lcd_wrx,
        output lcd_rdx,
        output lcd_d
    );

    modport slave (
        output cmd_data,
        input  cmd_pull,
        input  cmd_ready,
        input  lcd_csx,
        input  lcd_dcx,
        input  lcd_wrx,
        input  lcd_rdx,
        input  lcd_d
    );

endinterface

// File: rtl/lcd_cycle_timer.sv
// Loadable down-counter shared by the power-up wait and the write strobe phases.
module lcd_cycle_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // Saturates at zero so a phase that overstays never wraps into a new wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/lcd_bus_driver.sv
// Serialises the 9-bit lcd_controller command stream onto the 8080 parallel LCD bus.
module lcd_bus_driver
    import lcd_pkg::*;
#(
    parameter int WR_LOW_CYCLES  = 2,
    parameter int WR_HIGH_CYCLES = 2,
    parameter int POWERUP_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    lcd_bus_driver_if.master  bus
);

    localparam int TIMER_WIDTH =
        $clog2(max3(WR_LOW_CYCLES, WR_HIGH_CYCLES, POWERUP_CYCLES) + 1);

    // The first power-up cycle arms the timer and the last one raises cmd_ready.
    localparam logic [TIMER_WIDTH-1:0] PWRUP_LOAD =
        TIMER_WIDTH'((POWERUP_CYCLES >= 2) ? (POWERUP_CYCLES - 2) : 0);
    localparam logic [TIMER_WIDTH-1:0] WR_LO_LOAD = TIMER_WIDTH'(WR_LOW_CYCLES - 1);
    // WR_HI spans the rising-edge cycle plus WR_HIGH_CYCLES of data hold.
    localparam logic [TIMER_WIDTH-1:0] WR_HI_LOAD = TIMER_WIDTH'(WR_HIGH_CYCLES);

    bus_state_t state, state_next;
    logic       pwrup_armed, armed_next;
    logic       pull_q, pull_next;
    logic       ready_q, ready_next;
    logic       csx_q, csx_next;
    logic       dcx_q, dcx_next;
    logic       wrx_q, wrx_next;
    logic [7:0] d_q, d_next;
    logic                   timer_load;
    logic [TIMER_WIDTH-1:0] timer_value;
    logic                   timer_done;

    lcd_cycle_timer #(
        .WIDTH(TIMER_WIDTH)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (timer_load),
        .load_value(timer_value),
        .done      (timer_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= PWRUP;
            pwrup_armed <= 1'b0;
            pull_q      <= 1'b0;
            ready_q     <= 1'b0;
            csx_q       <= 1'b1;
            dcx_q       <= 1'b1;
            wrx_q       <= 1'b1;
            d_q         <= 8'h00;
        end else begin
            state       <= state_next;
            pwrup_armed <= armed_next;
            pull_q      <= pull_next;
            ready_q     <= ready_next;
            csx_q       <= csx_next;
            dcx_q       <= dcx_next;
            wrx_q       <= wrx_next;
            d_q         <= d_next;
        end
    end

    // Outputs are computed one state ahead so every bus pin comes straight from a flop.
    always_comb begin
        state_next  = state;
        armed_next  = pwrup_armed;
        pull_next   = 1'b0;
        ready_next  = ready_q;
        csx_next    = csx_q;
        dcx_next    = dcx_q;
        wrx_next    = wrx_q;
        d_next      = d_q;
        timer_load  = 1'b0;
        timer_value = '0;
        case (state)
            PWRUP: begin
                if (ready_q) begin
                    state_next = IDLE;
                    pull_next  = 1'b1;
                end else if (!pwrup_armed) begin
                    armed_next = 1'b1;
                    if (POWERUP_CYCLES <= 1) begin
                        ready_next = 1'b1;
                    end else begin
                        timer_load  = 1'b1;
                        timer_value = PWRUP_LOAD;
                    end
                end else if (timer_done) begin
                    ready_next = 1'b1;
                end
            end
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                if (bus.cmd_data == LCD_CMD_NOP) begin
                    state_next = IDLE;
                    pull_next  = 1'b1;
                end else begin
                    state_next = SETUP;
                    d_next     = bus.cmd_data[7:0];
                    dcx_next   = ~bus.cmd_data[LCD_CMD_FLAG_BIT];
                    csx_next   = 1'b0;
                end
            end
            SETUP: begin
                state_next  = WR_LO;
                wrx_next    = 1'b0;
                timer_load  = 1'b1;
                timer_value = WR_LO_LOAD;
            end
            WR_LO: begin
                if (timer_done) begin
                    state_next  = WR_HI;
                    wrx_next    = 1'b1;
                    timer_load  = 1'b1;
                    timer_value = WR_HI_LOAD;
                end
            end
            WR_HI: begin
                if (timer_done) begin
                    state_next = IDLE;
                    csx_next   = 1'b1;
                    pull_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                csx_next   = 1'b1;
                dcx_next   = 1'b1;
                wrx_next   = 1'b1;
                d_next     = 8'h00;
                pull_next  = ready_q;
            end
        endcase
    end

    assign bus.cmd_pull  = pull_q;
    assign bus.cmd_ready = ready_q;
    assign bus.lcd_csx   = csx_q;
    assign bus.lcd_dcx   = dcx_q;
    assign bus.lcd_wrx   = wrx_q;
    assign bus.lcd_rdx   = 1'b1;
    assign bus.lcd_d     = d_q;

endmodule
